// File: rtl/lot_pkg.sv
// Shared types and helpers for the parking-lot occupancy tracker.
// Event encoding matches the {enter, exit} bit pair directly.
package lot_pkg;

    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_OUT  = 2'b01,
        EV_IN   = 2'b10,
        EV_BOTH = 2'b11
    } ev_e;

    function automatic int unsigned calc_cw(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter saturating at 0 and MAX; inc and dec together hold the value.
// sat_hit_* flag a request that was absorbed by saturation this cycle.
module sat_updown_counter #(
    parameter int unsigned MAX = 16,
    parameter int unsigned W   = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max,
    output logic         at_min,
    output logic         sat_hit_max,
    output logic         sat_hit_min
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] q_d, q_q;

    assign at_max      = (q_q == MaxVal);
    assign at_min      = (q_q == '0);
    assign sat_hit_max = inc & ~dec & at_max;
    assign sat_hit_min = dec & ~inc & at_min;
    assign q           = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !dec && !at_max) begin
            q_d = q_q + W'(1);
        end else if (dec && !inc && !at_min) begin
            q_d = q_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/lot_occupancy.sv
// Lot occupancy tracker: count/full/empty, total entries and sticky error flags.
// Define LOT_OCCUPANCY_PEAK_EN to enable the peak-occupancy register.
module lot_occupancy
    import lot_pkg::*;
#(
    parameter  int unsigned CAPACITY = 16,
    parameter  int unsigned TOTAL_W  = 16,
    localparam int unsigned CW       = calc_cw(CAPACITY)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enter,
    input  logic               exit,
    input  logic               clear,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic [TOTAL_W-1:0] total,
    output logic               err_overflow,
    output logic               err_underflow,
    output logic [CW-1:0]      peak
);

    ev_e ev;
    logic at_max, at_min, sat_hit_max, sat_hit_min;

    logic [TOTAL_W-1:0] total_d, total_q;
    logic               err_overflow_d, err_overflow_q;
    logic               err_underflow_d, err_underflow_q;

    assign ev = ev_e'({enter, exit});

    sat_updown_counter #(
        .MAX (CAPACITY),
        .W   (CW)
    ) u_count (
        .clk         (clk),
        .reset       (reset),
        .inc         (enter),
        .dec         (exit),
        .clr         (clear),
        .q           (count),
        .at_max      (at_max),
        .at_min      (at_min),
        .sat_hit_max (sat_hit_max),
        .sat_hit_min (sat_hit_min)
    );

    always_comb begin
        total_d         = total_q;
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;
        if (clear) begin
            total_d         = '0;
            err_overflow_d  = 1'b0;
            err_underflow_d = 1'b0;
        end else begin
            // Every entry counts toward total, even one absorbed at full.
            unique case (ev)
                EV_IN: begin
                    total_d = total_q + TOTAL_W'(1);
                    if (sat_hit_max) err_overflow_d = 1'b1;
                end
                EV_OUT: begin
                    if (sat_hit_min) err_underflow_d = 1'b1;
                end
                EV_BOTH: total_d = total_q + TOTAL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q         <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            total_q         <= total_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign full          = at_max;
    assign empty         = at_min;
    assign total         = total_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

`ifdef LOT_OCCUPANCY_PEAK_EN
    logic [CW-1:0] peak_d, peak_q;

    // peak >= count always, so count can only pass peak by stepping up from it.
    always_comb begin
        peak_d = peak_q;
        if (clear) begin
            peak_d = '0;
        end else if (ev == EV_IN && !at_max && count == peak_q) begin
            peak_d = peak_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_lot_occupancy.sv
// Scoreboard bench for lot_occupancy with CAPACITY=3, TOTAL_W=4.
// Honours LOT_OCCUPANCY_PEAK_EN for the expected peak values.
module tb_lot_occupancy;

    localparam int unsigned Cap = 3;
    localparam int unsigned Tw  = 4;

    typedef struct packed {
        logic [1:0]    count;
        logic          full;
        logic          empty;
        logic [Tw-1:0] total;
        logic          ovf;
        logic          unf;
        logic [1:0]    peak;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enter = 1'b0;
    logic          exit = 1'b0;
    logic          clear = 1'b0;
    logic [1:0]    count;
    logic          full, empty;
    logic [Tw-1:0] total;
    logic          err_overflow, err_underflow;
    logic [1:0]    peak;

    int tests = 0;
    int fails = 0;
    int step_no = 0;

    obs_t exp_q[$];
    int   tag_q[$];

    always #5 clk = ~clk;

    lot_occupancy #(
        .CAPACITY (Cap),
        .TOTAL_W  (Tw)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enter         (enter),
        .exit          (exit),
        .clear         (clear),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .total         (total),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .peak          (peak)
    );

    function automatic logic [1:0] pk(input int v);
`ifdef LOT_OCCUPANCY_PEAK_EN
        return 2'(v);
`else
        return 2'(v * 0);
`endif
    endfunction

    function automatic obs_t mk(input int c, input int t, input bit o, input bit u, input int p);
        obs_t e;
        e.count = 2'(c);
        e.full  = (c == Cap);
        e.empty = (c == 0);
        e.total = Tw'(t);
        e.ovf   = o;
        e.unf   = u;
        e.peak  = pk(p);
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a = '{count, full, empty, total, err_overflow, err_underflow, peak};
        return a;
    endfunction

    task automatic compare(input string name, input int tag, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s #%0d: got cnt=%0d full=%0b empty=%0b tot=%0d ovf=%0b unf=%0b pk=%0d, want cnt=%0d full=%0b empty=%0b tot=%0d ovf=%0b unf=%0b pk=%0d",
                     name, tag, act.count, act.full, act.empty, act.total, act.ovf, act.unf,
                     act.peak, exp.count, exp.full, exp.empty, exp.total, exp.ovf, exp.unf,
                     exp.peak);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input bit e, input bit x, input bit c,
                        input int cnt, input int tot, input bit o, input bit u, input int p);
        @(negedge clk);
        enter = e;
        exit  = x;
        clear = c;
        exp_q.push_back(mk(cnt, tot, o, u, p));
        tag_q.push_back(step_no);
        step_no++;
    endtask

    initial begin : monitor
        obs_t e;
        int   t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                compare("step", t, sample(), e);
            end
        end
    end

    initial begin : stim
        int guard;
        #2;
        compare("reset_state", 0, sample(), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;

        // Exit while empty: underflow only, total untouched
        step(0, 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // Fill to capacity, then simultaneous events at full and at 2
        step(1, 0, 0, 1, 1, 0, 0, 1);
        step(1, 0, 0, 2, 2, 0, 0, 2);
        step(1, 0, 0, 3, 3, 0, 0, 3);
        step(1, 1, 0, 3, 4, 0, 0, 3);
        step(0, 1, 0, 2, 4, 0, 0, 3);
        step(1, 1, 0, 2, 5, 0, 0, 3);
        step(1, 0, 0, 3, 6, 0, 0, 3);
        // Entry while full: count saturates, total still advances
        step(1, 0, 0, 3, 7, 1, 0, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 3, 7, 1, 0, 3);
        step(0, 1, 0, 2, 7, 1, 0, 3);
        step(0, 1, 0, 1, 7, 1, 0, 3);
        step(0, 1, 0, 0, 7, 1, 0, 3);
        step(0, 1, 0, 0, 7, 1, 1, 3);
        step(1, 0, 0, 1, 8, 1, 1, 3);
        step(1, 0, 0, 2, 9, 1, 1, 3);
        // Clear wins over a same-cycle enter
        step(1, 0, 1, 0, 0, 0, 0, 0);

        // total wraps at 2^Tw; simultaneous events at empty raise no error
        for (int i = 1; i <= 16; i++) step(1, 1, 0, 0, i % 16, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 1);
        step(1, 0, 0, 2, 2, 0, 0, 2);
        step(0, 0, 0, 2, 2, 0, 0, 2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end

        // Asynchronous reset mid-cycle, checked away from any clock edge
        @(negedge clk);
        enter = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        compare("async_reset", 0, sample(), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        compare("reset_hold", 0, sample(), mk(0, 0, 0, 0, 0));
        enter = 1'b0;
        reset = 1'b1;
        step(1, 0, 0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0, 1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_end: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lot_occupancy.md
Name: lot_occupancy

Overview:
- Downstream consumer of the parking-lot car detector's one-cycle enter/exit pulses.
- Maintains current lot occupancy against a fixed capacity and produces full/empty status for the lot display/gate logic.
- Keeps a running count of total entries and sticky error flags for impossible events: entry when full, exit when empty.

Parameters:
- CAPACITY, 16, maximum number of cars the lot holds (>=1).
- TOTAL_W, 16, width of the total-entries counter.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  asynchronous active-low reset.
- enter  in  1  one-cycle pulse: a car has entered.
- exit  in  1  one-cycle pulse: a car has exited.
- clear  in  1  synchronous clear of all counters and error flags.
- count  out  CW  current occupancy, CW = $clog2(CAPACITY+1).
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- total  out  TOTAL_W  number of entries since reset/clear; wraps modulo 2^TOTAL_W.
- err_overflow  out  1  sticky: enter seen while full.
- err_underflow  out  1  sticky: exit seen while empty.
- peak  out  CW  highest count since reset/clear (see Optional Feature).

Behaviour:
- Reset (reset low, asynchronous): count=0, total=0, err_overflow=0, err_underflow=0, peak=0.
  - Consequently empty=1, full=0.
  - Deassertion is taken as synchronous to clk upstream.
- All outputs are registered or decoded directly from registers. A pulse sampled at edge N is reflected in the outputs after edge N (1-cycle latency).
- Per-edge priority: clear > {enter, exit} evaluation.
  - clear=1: count, total, peak and both error flags go to 0. enter/exit in the same cycle are ignored.
- Evaluation of {enter, exit} when clear=0:
  - 00: hold everything.
  - 10, not full: count+1, total+1.
  - 10, full: count holds at CAPACITY, total+1 (the car did pass), err_overflow<=1.
  - 01, not empty: count-1.
  - 01, empty: count holds at 0, err_underflow<=1.
  - 11 (simultaneous): count unchanged, total+1, no error set, even when full or empty.
- total wraps from 2^TOTAL_W-1 to 0 without any flag.
- Error flags are sticky: cleared only by reset or clear.
- full/empty are pure decodes of count. They are never both 1 (CAPACITY>=1).
- Pulse widths >1 cycle are not filtered: each cycle high counts as one event. Upstream guarantees single-cycle pulses.
- Reset mid-operation aborts immediately with no partial update.

Optional Feature:
- Macro: LOT_OCCUPANCY_PEAK_EN.
- Defined:
  - peak register tracks the maximum count ever reached.
  - peak updates on the same edge as count, so peak equals the new count when the new count exceeds the old peak.
  - Cleared by reset/clear.
- Undefined: peak is tied to 0 and no register is inferred. The port remains present so instantiations are identical.

Decomposition:
- Package lot_pkg:
  - localparam-derived function for CW (clog2 of CAPACITY+1).
  - enum for event decode {EV_NONE, EV_IN, EV_OUT, EV_BOTH} built from {enter, exit}.
- Sub-module sat_updown_counter (params MAX, W):
  - Ports: inc, dec, clr, q, at_max, at_min, sat_hit_max, sat_hit_min.
  - inc&dec together holds the value.
  - Used for count.
- The total counter and error flags stay in the top.

Test Plan:
- CAPACITY=3. Reset, then 3 enter pulses -> count 1,2,3 on successive edges; full=1 after the 3rd; total=3; empty=0.
- From full, 1 more enter -> count stays 3, total=4, err_overflow=1. Flag stays 1 through 5 idle cycles.
- From count=0 (after reset), exit pulse -> count=0, err_underflow=1, total=0.
- count=2, enter&exit same cycle -> count=2, total+1, no error flags. Repeat at count=3 -> count=3, err_overflow stays 0.
- count=2 with errors set, clear with enter in the same cycle -> count=0, total=0, both flags 0, empty=1.
- With LOT_OCCUPANCY_PEAK_EN: enter x3, exit x2 -> peak=3, count=1. Without the macro: peak=0 throughout. Also assert reset mid-sequence -> all outputs 0 immediately, without waiting for a clk edge.
